// File: rtl/sim_mem_pkg.sv
// Shared types and constants for the simulation memory bridge.
// Imported by the bridge top and its stall LFSR.
package sim_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] CON_ADDR_DEF   = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR_DEF  = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC_DEF = 32'd123456789;
  localparam logic [31:0] ERR_WORD       = 32'hDEAD_BEEF;

  // x^16+x^14+x^13+x^11+1, Fibonacci, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/stall_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step_i is high.
// The low two bits pick the extra wait states of a request.
module stall_lfsr16
  import sim_mem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step_i,
  output logic [1:0] bits_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb     = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_d = {fb, lfsr_q[15:1]};
  assign bits_o = lfsr_q[1:0];

  // seed on reset, one step per accepted request
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sim_mem_bridge.sv
// Picorv32 native-bus responder: firmware SRAM, console port,
// pass register and configurable wait states for the sim harness.
module sim_mem_bridge
  import sim_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 32768,
  parameter int          LATENCY    = 0,
  parameter int          RAND_STALL = 0,
  parameter logic [31:0] CON_ADDR   = CON_ADDR_DEF,
  parameter logic [31:0] PASS_ADDR  = PASS_ADDR_DEF,
  parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tests_passed,
  output logic        con_valid,
  output logic [7:0]  con_data,
  output logic        bus_error
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [4:0] LAT5 = 5'(LATENCY);

  // left uncleared by reset so the harness preload survives
  logic [31:0] sram [MEM_WORDS];

  state_t      state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d, wcnt_ld;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [29:0]   req_word;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          accept, commit, we;
  logic          sram_hit, con_hit, pass_hit;
  logic [AW-1:0] idx;
  logic [31:0]   rd_val;
  logic [1:0]    stall;

  logic [31:0] rdata_q;
  logic        passed_q;
  logic        con_valid_q;
  logic [7:0]  con_data_q;
  logic        err_q;
  logic        unused;

  assign unused = ^mem_addr[1:0];

  stall_lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .step_i (accept),
    .bits_o (stall)
  );

  assign wcnt_ld = LAT5 +
    ((RAND_STALL != 0) ? {3'b0, stall} : 5'd0);

  // zero-wait requests commit on the accepting edge,
  // so take the live inputs while still in IDLE
  assign req_word  = (state_q == IDLE) ? mem_addr[31:2] : addr_q;
  assign req_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
  assign req_wstrb = (state_q == IDLE) ? mem_wstrb : wstrb_q;

  assign we       = |req_wstrb;
  assign sram_hit = {2'b0, req_word} < 32'(MEM_WORDS);
  assign con_hit  = req_word == CON_ADDR[31:2];
  assign pass_hit = req_word == PASS_ADDR[31:2];
  assign idx      = req_word[AW-1:0];

  // response word for the request being committed
  always_comb begin
    rd_val = ERR_WORD;
    unique case (1'b1)
      sram_hit: rd_val = sram[idx];
      con_hit:  rd_val = '0;
      pass_hit: rd_val = {31'b0, passed_q};
      default:  ;
    endcase
  end

  // next state, wait counter and commit strobe
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          accept = 1'b1;
          wcnt_d = wcnt_ld;
          if (wcnt_ld == 5'd0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 5'd1;
        if (wcnt_q <= 5'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // byte-lane SRAM writes on the edge entering RESP
  always_ff @(posedge clock) begin
    if (reset && commit && sram_hit && we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          sram[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // state, request latch, response and sticky flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      passed_q    <= 1'b0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      con_valid_q <= 1'b0;
      if (accept) begin
        addr_q  <= mem_addr[31:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (commit) begin
        rdata_q <= rd_val;
        if (con_hit && we) begin
          con_valid_q <= 1'b1;
          con_data_q  <= req_wdata[7:0];
        end
        if (pass_hit && we && req_wdata == PASS_MAGIC) begin
          passed_q <= 1'b1;
        end
        if (!(sram_hit || con_hit || pass_hit)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign mem_ready    = state_q == RESP;
  assign mem_rdata    = rdata_q;
  assign tests_passed = passed_q;
  assign con_valid    = con_valid_q;
  assign con_data     = con_data_q;
  assign bus_error    = err_q;

endmodule

// File: doc/sim_mem_bridge.md
Name: sim_mem_bridge

Overview:
- Memory responder on the downstream side of the Picorv32 native memory interface (valid/ready/addr/wdata/wstrb/rdata) in the simulation harness.
- Holds a firmware SRAM loaded via $readmemh. Inserts configurable and pseudo-random wait states to stress the core's handshake.
- Decodes a console MMIO byte port and a test-pass register. The harness monitors both.

Parameters:
- MEM_WORDS, 32768: SRAM depth in 32-bit words; SRAM spans byte addresses 0 to MEM_WORDS*4-1.
- LATENCY, 0: fixed wait states per access, range 0-15.
- RAND_STALL, 0: 1 adds 0-3 extra wait states per access, taken from an LFSR.
- CON_ADDR, 32'h1000_0000: console write-only byte port.
- PASS_ADDR, 32'h2000_0000: test-pass register.
- PASS_MAGIC, 32'd123456789: value that sets tests_passed.

Ports:
- clock, in, 1: clock.
- reset, in, 1: synchronous, active-low.
- mem_valid, in, 1: core request.
- mem_ready, out, 1: one-cycle completion pulse.
- mem_addr, in, 32: byte address; bits [1:0] are ignored.
- mem_wdata, in, 32: write data.
- mem_wstrb, in, 4: byte write strobes; 0 means read.
- mem_rdata, out, 32: read data, valid while mem_ready=1.
- tests_passed, out, 1: sticky pass flag.
- con_valid, out, 1: one-cycle pulse per console byte.
- con_data, out, 8: console byte.
- bus_error, out, 1: sticky flag for an unmapped access.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - mem_ready=0, mem_rdata=0, tests_passed=0, con_valid=0, con_data=0, bus_error=0.
  - LFSR = 16'hACE1.
  - SRAM contents are NOT cleared, so preloaded firmware survives.
  - A reset mid-access aborts it with no write committed and no mem_ready.
- FSM states IDLE, WAIT, RESP.
  - IDLE: on mem_valid=1, latch addr, wdata and wstrb, and load wcnt = LATENCY + (RAND_STALL ? lfsr[1:0] : 0).
    - If the loaded wcnt is 0, go to RESP; otherwise go to WAIT.
    - Advance the LFSR one step per accepted request: x^16+x^14+x^13+x^11+1, Fibonacci form.
  - WAIT: decrement wcnt. When wcnt reaches 1, go to RESP on the next edge.
  - RESP: mem_ready=1 for exactly one cycle, then IDLE.
  - RESP to IDLE always consumes one cycle. A mem_valid seen in the RESP cycle is not accepted.
- Latency: with N total wait states, mem_ready is high in cycle T+1+N, where T is the cycle IDLE samples mem_valid.
- Access effects are committed on the edge entering RESP. Inputs are sampled from the latched copies, so a core that changes its inputs after acceptance is tolerated.
- Address decode uses the word address a = addr[31:2].
  - SRAM, when a < MEM_WORDS:
    - Read: mem_rdata = sram[a].
    - Write: only the byte lanes with wstrb[i]=1 are updated; mem_rdata = old sram[a].
  - CON_ADDR with wstrb != 0:
    - con_data = wdata[7:0], and con_valid pulses in the RESP cycle.
    - A read of CON_ADDR returns 0.
  - PASS_ADDR:
    - A write with wdata == PASS_MAGIC sets tests_passed; any other value leaves it unchanged.
    - A read returns {31'b0, tests_passed}.
  - Any other address: bus_error is set (sticky), a read returns 32'hDEAD_BEEF, and a write is dropped. mem_ready is still given, so the core never hangs.
- mem_rdata holds its last value outside RESP.
- A partial wstrb on an MMIO write uses wdata as-is; strobes are only checked for non-zero.

Decomposition:
- Shared package sim_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the CON_ADDR, PASS_ADDR and PASS_MAGIC defaults;
  - the 32'hDEAD_BEEF error pattern;
  - the LFSR seed and taps.
- One sub-module, stall_lfsr16: a 16-bit LFSR with a step enable, exposing [1:0].
- The SRAM array stays in the top so the harness can load it hierarchically (s_mem.sram-style path: sim_mem_bridge.sram).

Test Plan:
- LATENCY=0, RAND_STALL=0: preload sram[4]=32'h1234_5678, read addr 0x10 → mem_ready in the cycle after acceptance, mem_rdata=32'h1234_5678.
- LATENCY=3: write addr 0x20, wdata 32'hAABB_CCDD, wstrb 4'b0101, over old value 0 → ready 4 cycles after acceptance; a readback returns 32'h00BB_00DD.
- Write 32'h41 to CON_ADDR, then 123456789 to PASS_ADDR → con_valid pulses once with con_data=8'h41, then tests_passed=1. A later write of 0 to PASS_ADDR leaves it at 1.
- Read 0x3000_0000 → mem_rdata=32'hDEAD_BEEF, bus_error=1 and sticky; the next SRAM access completes normally.
- RAND_STALL=1, LATENCY=1, with 1000 back-to-back reads → every ready lands 2-5 cycles after acceptance, the read data always matches the SRAM model, and mem_ready is never high two cycles in a row.
- Assert reset=0 during WAIT of a write → no SRAM change, mem_ready stays 0, all flags read 0. SRAM preload is intact after reset is released.
